// File: rtl/dec8_rr_sched.sv
// dec8_rr_sched: round-robin owner select for a shared 3-to-8 decoded resource.
// Grants are held until done, request withdrawal, or a MAX_HOLD-cycle limit.
module dec8_rr_sched #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d, ptr_q, ptr_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d, rel;
  // Descending scan leaves the lowest rotated offset from ptr as the winner.
  always_comb begin
    pick = ptr_q;
    for (int i = 7; i >= 0; i--)
      if (req[ptr_q + 3'(i)]) pick = ptr_q + 3'(i);
  end
  assign rel = done || !req[sel_q] || cnt_q == CNT_W'(MAX_HOLD - 1);
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      state_d = |req ? BUSY : IDLE;
      sel_d   = |req ? pick : sel_q;
      cnt_d   = '0;
    end else if (rel) begin
      state_d = IDLE;
      ptr_d   = sel_q + 3'd1;
      cnt_d   = '0;
      to_d    = !done && req[sel_q];
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  assign sel     = sel_q;
  assign en      = state_q == BUSY;
  assign busy    = state_q == BUSY;
  assign timeout = to_q;
endmodule

// File: tb/tb_dec8_rr_sched.sv
// tb_dec8_rr_sched: scenario tasks against a cycle model feeding a scoreboard queue.
module tb_dec8_rr_sched;
  localparam int MAX_HOLD = 16;
  logic       clk = 1'b0, rst = 1'b1, done = 1'b0, en, busy, timeout;
  logic [7:0] req = '0;
  logic [2:0] sel;
  int errors = 0, checks = 0;
  logic [5:0] sb[$];
  bit m_busy, m_to;
  int m_sel, m_ptr, m_cnt;

  dec8_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .en(en), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, advance the model and queue its expectation.
  task automatic step(input logic [7:0] r, input logic d);
    bit f;
    @(negedge clk);
    req = r; done = d;
    if (!m_busy) begin
      m_to = 0;
      if (r != 0) begin
        f = 0;
        for (int k = 0; k < 8; k++)
          if (!f && r[(m_ptr + k) % 8]) begin m_sel = (m_ptr + k) % 8; f = 1; end
        m_busy = 1; m_cnt = 0;
      end
    end else if (d || !r[m_sel] || m_cnt == MAX_HOLD - 1) begin
      m_to = !d && r[m_sel];
      m_busy = 0; m_ptr = (m_sel + 1) % 8; m_cnt = 0;
    end else begin
      m_cnt++; m_to = 0;
    end
    sb.push_back({m_busy, m_busy, 3'(m_sel), m_to});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    do_reset();
    checks++;
    if ({en, busy, sel, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000000", {en, busy, sel, timeout});
    end
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL idle_done step %0d: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_single();
    logic [5:0] got, exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h01, i == 3);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL single step %0d: got %b expected %b", i, got, exp); end
      checks++;
      if (en !== (i < 3)) begin errors++; $display("FAIL single_en step %0d: got %b expected %b", i, en, i < 3); end
    end
    step(8'h03, 1'b0);
    got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
    if (got !== exp || sel !== 3'd1) begin errors++; $display("FAIL single_next: got %b expected %b sel 1", got, exp); end
  endtask

  task automatic test_rr_order();
    logic [5:0] got, exp;
    do_reset();
    for (int g = 0; g < 9; g++)
      for (int c = 0; c < 3; c++) begin
        step(8'hFF, c == 2);
        got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rr grant %0d cyc %0d: got %b expected %b", g, c, got, exp); end
        if (c == 0) begin
          checks++;
          if (sel !== 3'(g % 8) || en !== 1'b1) begin errors++; $display("FAIL rr_sel grant %0d: got sel=%0d en=%b expected sel=%0d en=1", g, sel, en, g % 8); end
        end
      end
  endtask

  task automatic test_wrap();
    logic [5:0] got, exp;
    logic [7:0] r;
    logic [2:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      r = (i < 2) ? 8'h20 : 8'h03;
      step(r, i[0]);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap step %0d: got %b expected %b", i, got, exp); end
      if (!i[0]) begin
        want = (i == 0) ? 3'd5 : (i == 2) ? 3'd0 : 3'd1;
        checks++;
        if (sel !== want) begin errors++; $display("FAIL wrap_sel step %0d: got %0d expected %0d", i, sel, want); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0] got, exp;
    int on = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(8'h08, 1'b0);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout step %0d: got %b expected %b", i, got, exp); end
      if (i < 16 && en === 1'b1 && sel === 3'd3) on++;
      if (i == 16) begin
        checks++;
        if (en !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got en=%b to=%b expected en=0 to=1", en, timeout); end
      end
      if (i == 17) begin
        checks++;
        if (en !== 1'b1 || sel !== 3'd3 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_regrant: got en=%b sel=%0d to=%b expected 1 3 0", en, sel, timeout); end
      end
    end
    checks++;
    if (on != MAX_HOLD) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", on, MAX_HOLD); end
  endtask

  task automatic test_done_limit();
    logic [5:0] got, exp;
    logic [7:0] r;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      r = (i == 19) ? 8'h00 : 8'h08;
      step(r, i == 16);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL done_limit step %0d: got %b expected %b", i, got, exp); end
      if (i == 16 || i == 19) begin
        checks++;
        if (en !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL release_%0d: got en=%b to=%b expected en=0 to=0", i, en, timeout); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] got, exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'h40, 1'b0);
      got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL pre_rst step %0d: got %b expected %b", i, got, exp); end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({en, busy, sel} !== 5'b0) begin errors++; $display("FAIL async_rst: got en=%b busy=%b sel=%0d expected 0 0 0", en, busy, sel); end
    @(negedge clk);
    rst = 1'b0; req = '0;
    model_reset();
    step(8'h80, 1'b0);
    got = {en, busy, sel, timeout}; exp = sb.pop_front(); checks++;
    if (got !== exp || sel !== 3'd7) begin errors++; $display("FAIL post_rst: got %b expected %b sel 7", got, exp); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rr_order();
    test_wrap();
    test_timeout();
    test_done_limit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
